// File: rtl/rx_pkg.sv
// rx_pkg: shared types and defaults for the receive frame sequencer.
package rx_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_HUNT, ST_START, ST_DATA, ST_STOP} state_t;

    localparam int SPB_DEF   = 10;
    localparam int NBITS_DEF = 8;

    // Strict majority; an exact tie falls below this and resolves to 0.
    function automatic int maj_thr(input int spb);
        return spb / 2 + 1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running divider producing a one-cycle sample strobe.
module sample_tick_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 40_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_max;

    assign w_max  = r_cnt == CW'(DIV - 1);
    assign o_tick = w_max;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= w_max ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: samples rx_in at SAMPLE_HZ, frames start/data/stop bits
// with majority voting and hands bytes out over a valid/ready handshake.
module rx_frame_sequencer
    import rx_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SAMPLE_HZ    = 40_000,
    parameter int SPB          = SPB_DEF,
    parameter int NBITS        = NBITS_DEF,
    parameter int IDLE_SAMPLES = 20
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             rx_in,
    input  logic             enable,
    output logic [NBITS-1:0] code,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int OW  = $clog2(SPB + 1);
    localparam int BW  = $clog2(NBITS + 1);
    localparam int IW  = $clog2(IDLE_SAMPLES + 1);
    localparam int THR = maj_thr(SPB);

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [IW-1:0]    r_idle;
    logic [OW-1:0]    r_ones;
    logic [OW-1:0]    r_samp;
    logic [BW-1:0]    r_bits;
    logic [NBITS-1:0] r_shift;
    logic             w_tick;
    logic             w_rx;
    logic [OW-1:0]    w_ones;
    logic             w_last;
    logic             w_bit;

    sample_tick_gen #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ)) u_tick (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .o_tick  (w_tick)
    );

    // w_ones/w_bit include the sample being taken this tick.
    assign w_rx   = r_sync[1];
    assign w_ones = r_ones + OW'(w_rx);
    assign w_last = r_samp == OW'(SPB - 1);
    assign w_bit  = w_ones >= OW'(THR);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync     <= 2'b11;
            r_state    <= ST_IDLE;
            r_idle     <= '0;
            r_ones     <= '0;
            r_samp     <= '0;
            r_bits     <= '0;
            r_shift    <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx_in};
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (code_valid && code_ready) code_valid <= 1'b0;
            if (!enable) begin
                r_state <= ST_IDLE;
                busy    <= 1'b0;
                r_idle  <= '0;
                r_ones  <= '0;
                r_samp  <= '0;
                r_bits  <= '0;
                r_shift <= '0;
            end else if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rx) r_idle <= '0;
                        else if (r_idle == IW'(IDLE_SAMPLES - 1)) begin
                            r_idle  <= '0;
                            r_state <= ST_HUNT;
                        end else r_idle <= r_idle + 1'b1;
                    end
                    ST_HUNT: begin
                        if (!w_rx) begin
                            r_state <= ST_START;
                            busy    <= 1'b1;
                            r_samp  <= OW'(1);
                            r_ones  <= '0;
                        end
                    end
                    ST_START: begin
                        if (!w_last) begin
                            r_samp <= r_samp + 1'b1;
                            r_ones <= w_ones;
                        end else begin
                            r_samp <= '0;
                            r_ones <= '0;
                            r_bits <= '0;
                            if (w_ones <= OW'(SPB / 2)) r_state <= ST_DATA;
                            else begin
                                r_state <= ST_HUNT;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (!w_last) begin
                            r_samp <= r_samp + 1'b1;
                            r_ones <= w_ones;
                        end else begin
                            r_samp  <= '0;
                            r_ones  <= '0;
                            r_shift <= {w_bit, r_shift[NBITS-1:1]};
                            r_bits  <= r_bits + 1'b1;
                            if (r_bits == BW'(NBITS - 1)) r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (!w_last) begin
                            r_samp <= r_samp + 1'b1;
                            r_ones <= w_ones;
                        end else begin
                            r_samp  <= '0;
                            r_ones  <= '0;
                            r_bits  <= '0;
                            r_state <= ST_HUNT;
                            busy    <= 1'b0;
                            if (!w_bit) frame_err <= 1'b1;
                            else if (!code_valid || code_ready) begin
                                code       <= r_shift;
                                code_valid <= 1'b1;
                            end else overrun <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb_rx_frame_sequencer: randomized frame stimulus with a sample-count reference
// model feeding an event scoreboard checked by an independent monitor.
module tb_rx_frame_sequencer;
    localparam int DIV = 4;
    localparam int SPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       enable = 1'b0;
    logic       code_ready = 1'b1;
    logic [7:0] code;
    logic       code_valid, frame_err, overrun, busy;

    int n_checks = 0;
    int n_errs = 0;

    typedef enum int {EV_CODE, EV_ERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] code;
    } ev_t;

    ev_t        exp_q[$];
    bit         pending = 1'b0;
    logic [7:0] last_code = 8'h00;
    bit         prev_v = 1'b0;
    bit         prev_hs = 1'b0;

    always #5 clk = ~clk;

    rx_frame_sequencer #(.CLK_HZ(DIV), .SAMPLE_HZ(1)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .rx_in      (rx_in),
        .enable     (enable),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input ev_kind_t kind, input logic [7:0] c);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL event: got %s code %02h, nothing expected", kind.name(), c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.code !== c) begin
                n_errs++;
                $display("FAIL event: got %s code %02h expected %s code %02h",
                         kind.name(), c, e.kind.name(), e.code);
            end
        end
    endtask

    // Each sample holds the line for exactly one tick period.
    task automatic send(input bit b);
        rx_in = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b1);
    endtask

    // Builds a frame as SPB-sample groups with nk minority samples per group
    // (random up to nk if rnd); tie forces data bit 'tie' to exactly SPB/2 ones.
    // Expected outcome comes from the generated ones counts; cut<10 sends a partial frame.
    task automatic send_frame(input logic [7:0] d, input int nk, input bit rnd,
                              input bit stop_ok, input int tie, input int cut);
        bit         smp[$];
        bit         grp[$];
        logic [7:0] got;
        int         stop_ones, k, ones, j;
        bit         v, t;
        got = 8'h00;
        stop_ones = 0;
        for (int g = 0; g < 10; g++) begin
            v = (g == 0) ? 1'b0 : (g == 9) ? stop_ok : d[g-1];
            k = rnd ? int'($urandom_range(0, nk)) : nk;
            ones = v ? SPB - k : k;
            if (tie >= 0 && g == tie + 1) ones = SPB / 2;
            grp.delete();
            for (int i = 0; i < SPB - (g == 0 ? 1 : 0); i++) grp.push_back(i < ones);
            for (int i = grp.size() - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = grp[i];
                grp[i] = grp[j];
                grp[j] = t;
            end
            if (g == 0) grp.push_front(1'b0);
            foreach (grp[i]) smp.push_back(grp[i]);
            if (g >= 1 && g <= 8) got[g-1] = ones > SPB / 2;
            if (g == 9) stop_ones = ones;
        end
        if (cut == 10) begin
            if (stop_ones <= SPB / 2) exp_q.push_back('{EV_ERR, last_code});
            else if (pending) exp_q.push_back('{EV_OVR, last_code});
            else begin
                exp_q.push_back('{EV_CODE, got});
                last_code = got;
                pending = !code_ready;
            end
        end
        for (int i = 0; i < cut * SPB; i++) send(smp[i]);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (frame_err) check_ev(EV_ERR, code);
            if (overrun) check_ev(EV_OVR, code);
            if (code_valid && (!prev_v || prev_hs)) check_ev(EV_CODE, code);
            prev_hs = code_valid && code_ready;
            prev_v = code_valid;
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish, %0d events outstanding", exp_q.size());
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_code", code, 8'h00);
        check("reset_code_valid", code_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;
        idle(22);

        send_frame(8'hA5, 0, 1'b0, 1'b1, -1, 10);
        idle(3);
        check("code_hold_a5", code, 8'hA5);

        repeat (3) send(1'b0);
        repeat (3) send(1'b1);
        @(negedge clk);
        check("glitch_busy_high", busy, 1);
        @(posedge clk);
        #1;
        idle(10);
        @(negedge clk);
        check("glitch_busy_low", busy, 0);
        @(posedge clk);
        #1;
        idle(2);
        send_frame(8'h3C, 0, 1'b0, 1'b1, -1, 10);
        idle(3);

        send_frame(8'h5A, 0, 1'b0, 1'b0, -1, 10);
        idle(3);
        @(negedge clk);
        check("stop_err_valid", code_valid, 0);
        check("stop_err_code", code, 8'h3C);
        @(posedge clk);
        #1;

        code_ready = 1'b0;
        send_frame(8'h11, 0, 1'b0, 1'b1, -1, 10);
        idle(3);
        send_frame(8'h22, 0, 1'b0, 1'b1, -1, 10);
        idle(3);
        @(negedge clk);
        check("ovr_code", code, 8'h11);
        check("ovr_valid", code_valid, 1);
        @(posedge clk);
        #1;
        code_ready = 1'b1;
        pending = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_clears", code_valid, 0);
        @(posedge clk);
        #1;

        send_frame(8'hFF, 4, 1'b0, 1'b1, 0, 10);
        idle(3);
        check("tie_code", code, 8'hFE);

        code_ready = 1'b0;
        send_frame(8'h44, 2, 1'b1, 1'b1, -1, 10);
        idle(3);
        send_frame(8'h99, 0, 1'b0, 1'b1, -1, 5);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid_kept", code_valid, 1);
        check("abort_code_kept", code, 8'h44);
        @(posedge clk);
        #1;
        enable = 1'b1;
        code_ready = 1'b1;
        pending = 1'b0;
        idle(22);
        send_frame(8'h81, 0, 1'b0, 1'b1, -1, 10);
        idle(3);
        check("after_abort_code", code, 8'h81);

        send_frame(8'h77, 0, 1'b0, 1'b1, -1, 5);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_reset_code", code, 8'h00);
        check("mid_reset_valid", code_valid, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_err", frame_err | overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_code = 8'h00;
        pending = 1'b0;
        idle(22);
        send_frame(8'h81, 0, 1'b0, 1'b1, -1, 10);
        idle(3);

        for (int n = 0; n < 12; n++) begin
            code_ready = $urandom_range(0, 3) != 0;
            if (code_ready) pending = 1'b0;
            send_frame(8'($urandom), 4, 1'b1, $urandom_range(0, 7) != 0,
                       $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 7)) : -1, 10);
            idle($urandom_range(2, 5));
        end

        code_ready = 1'b1;
        idle(3);
        check("events_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
